// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : Load/store unit: word-aligned byte-enabled data memory access
//            over req/ack with timeout, extended load data for writeback.
//            Optional macro DMEM_MISALIGN_TRAP_EN: trap misaligned accesses
//            (err 01) instead of clearing the offending address bits.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] DMEM_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    localparam logic [1:0] c_err_ok      = 2'b00;
    localparam logic [1:0] c_err_timeout = 2'b10;
    localparam logic [1:0] c_err_illegal = 2'b11;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;
    logic [31:0] r_load_data;
    logic [1:0]  r_err;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_legal;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_word_addr;
    logic [1:0]  w_err_accept;
    logic        w_bad;
    logic        w_timeout_hit;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic        w_misaligned;
`endif

    assign w_accept      = req_valid && (r_state == c_idle);
    assign w_word_addr   = (addr - DMEM_BASE) & 32'hFFFF_FFFC;
    assign w_timeout_hit = (r_cnt == c_timeout_last);

    // Request decode, evaluated on the raw request fields at accept time
    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_we;
            default:                w_legal = 1'b0;
        endcase

`ifdef DMEM_MISALIGN_TRAP_EN
        w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_off = addr[1:0];
`else
        case (funct3[1:0])
            2'b01:   w_off = {addr[1], 1'b0};
            2'b10:   w_off = 2'b00;
            default: w_off = addr[1:0];
        endcase
`endif

        w_be    = 4'b1111;
        w_wdata = store_data;
        if (req_we) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end

        if (!w_legal)
            w_err_accept = c_err_illegal;
`ifdef DMEM_MISALIGN_TRAP_EN
        else if (w_misaligned)
            w_err_accept = 2'b01;
`endif
        else
            w_err_accept = c_err_ok;

        w_bad = (w_err_accept != c_err_ok);
    end

    // Load lane select and extension
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ext = {24'd0, w_shifted[7:0]};
            3'b101:  w_ext = {16'd0, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_idle;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_next_state = w_bad ? c_done : c_issue;
            c_issue: if (mem_ack || w_timeout_hit) w_next_state = c_done;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        req_ready = (r_state == c_idle);
        done      = (r_state == c_done);
        mem_req   = (r_state == c_issue);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_cnt       <= 8'd0;
            r_load_data <= 32'd0;
            r_err       <= c_err_ok;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= funct3;
            r_off    <= w_off;
            r_cnt    <= 8'd0;
            r_err    <= w_err_accept;
            if (!w_bad) begin
                r_mem_we    <= req_we;
                r_mem_addr  <= w_word_addr;
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
            end
        end else if (r_state == c_issue) begin
            r_cnt <= r_cnt + 8'd1;
            // Ack takes priority over a timeout on the same edge
            if (mem_ack) begin
                r_err <= c_err_ok;
                if (!r_we)
                    r_load_data <= w_ext;
            end else if (w_timeout_hit) begin
                r_err       <= c_err_timeout;
                r_load_data <= 32'd0;
            end
        end
    end

    assign load_data = r_load_data;
    assign err_code  = r_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Directed self-checking bench for dmem_lsu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] load_data;
    logic        done;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.TIMEOUT(16), .DMEM_BASE(32'h0)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .done       (done),
        .err_code   (err_code),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Present a request for one edge; returns at the negedge after accept
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        funct3     = f3;
        addr       = a;
        store_data = d;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Full access acknowledged one cycle after accept
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdata, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_load);
        send(we, f3, a, d);
        check({tag, ".mem_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, we});
        check({tag, ".mem_addr"}, mem_addr, exp_maddr);
        check({tag, ".mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
        if (we)
            check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, ".done_early"}, {31'd0, done}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".mem_req_off"}, {31'd0, mem_req}, 32'd0);
        check({tag, ".err"}, {30'd0, err_code}, 32'd0);
        check({tag, ".load_data"}, load_data, exp_load);
        @(negedge clk);
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int seen_done;

        #12;
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.err", {30'd0, err_code}, 32'd0);
        check("rst.load_data", load_data, 32'd0);
        check("rst.mem_req", {31'd0, mem_req}, 32'd0);
        check("rst.mem_we", {31'd0, mem_we}, 32'd0);
        check("rst.mem_be", {28'd0, mem_be}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        access("sw",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0);
        access("lb",  1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF1234, 32'h10, 4'b1111, 32'h0, 32'hFFFFFF80);
        access("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF1234, 32'h10, 4'b1111, 32'h0, 32'h00000080);
        access("lh",  1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF1234, 32'h10, 4'b1111, 32'h0, 32'hFFFF80FF);
        access("sb",  1'b1, 3'b000, 32'h21, 32'hAB, 32'h0, 32'h20, 4'b0010, 32'hABABABAB, 32'hFFFF80FF);
        access("sh",  1'b1, 3'b001, 32'h22, 32'h1234, 32'h0, 32'h20, 4'b1100, 32'h12341234, 32'hFFFF80FF);
        access("lhu", 1'b0, 3'b101, 32'h40, 32'h0, 32'h1234_F00D, 32'h40, 4'b1111, 32'h0, 32'h0000F00D);
        access("lw",  1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_0001, 32'h44, 4'b1111, 32'h0, 32'hCAFE0001);

        // Timeout: no ack
        send(1'b0, 3'b010, 32'h30, 32'h0);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to.issue_cycles", n, 32'd16);
        check("to.done", {31'd0, done}, 32'd1);
        check("to.err", {30'd0, err_code}, 32'd2);
        check("to.load_data", load_data, 32'd0);
        @(negedge clk);
        check("to.ready", {31'd0, req_ready}, 32'd1);

        // Illegal funct3
        send(1'b0, 3'b011, 32'h50, 32'h0);
        check("ill.mem_req", {31'd0, mem_req}, 32'd0);
        check("ill.done", {31'd0, done}, 32'd1);
        check("ill.err", {30'd0, err_code}, 32'd3);
        @(negedge clk);
        check("ill.mem_req2", {31'd0, mem_req}, 32'd0);
        check("ill.ready", {31'd0, req_ready}, 32'd1);

        // Misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
        send(1'b0, 3'b010, 32'h102, 32'h0);
        check("mis.mem_req", {31'd0, mem_req}, 32'd0);
        check("mis.done", {31'd0, done}, 32'd1);
        check("mis.err", {30'd0, err_code}, 32'd1);
        @(negedge clk);
`else
        access("mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h1357_9BDF, 32'h100, 4'b1111, 32'h0, 32'h13579BDF);
`endif

        // Reset during ISSUE
        send(1'b1, 3'b010, 32'h60, 32'h11223344);
        check("rsti.mem_req_before", {31'd0, mem_req}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rsti.mem_req", {31'd0, mem_req}, 32'd0);
        check("rsti.ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        seen_done = 0;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen_done = 1;
            @(negedge clk);
        end
        check("rsti.no_done", seen_done, 32'd0);
        check("rsti.ready_after", {31'd0, req_ready}, 32'd1);
        check("rsti.mem_addr", mem_addr, 32'd0);
        check("rsti.load_data", load_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the ALU result and the data memory. Its output drives the writeback mux dmem input, which is currently tied to 32'd0.
- Accepts one access per request using the ALU address, rs2 data, MemRW and funct3.
- Issues a word-aligned, byte-enabled request to data memory over a req/ack handshake, with a timeout.
- Returns sign- or zero-extended load data to writeback, plus a completion pulse the control path uses as a stall release.

Parameters:
- TIMEOUT, 16, maximum cycles spent in ISSUE waiting for mem_ack before aborting (range 2..255).
- DMEM_BASE, 32'h00000000, byte offset subtracted from addr before driving mem_addr.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  access request from execute
- req_ready  output  1  unit idle; a request is accepted when req_valid and req_ready are both high at a rising edge
- req_we  input  1  1 = store, 0 = load (MemRW)
- funct3  input  3  RISC-V size/sign field
- addr  input  32  byte address (ALU_out)
- store_data  input  32  rs2 value
- load_data  output  32  extended load result, to the writeback mux
- done  output  1  one-cycle completion pulse
- err_code  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid while done=1
- mem_req  output  1  memory request strobe
- mem_we  output  1  memory write
- mem_addr  output  32  word address; bits [1:0] always 0
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  memory read data, valid with mem_ack
- mem_ack  input  1  memory completion, sampled at a rising edge

Behaviour:
- Reset values: state IDLE, req_ready=1, done=0, err_code=00, load_data=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0. Reset is asynchronous: asserting it mid-access drops mem_req immediately and discards the access. An ack arriving after reset, or at any time in IDLE, is ignored.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: req_ready=1. On an accepted request:
  - Latch the request fields and decode them.
  - A legal, aligned request moves to ISSUE.
  - An illegal funct3 or a misaligned request moves directly to DONE with the matching err_code; no memory access is made.
- ISSUE:
  - mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata stable and registered.
  - Counter increments each cycle.
  - mem_ack high at an edge: capture and extend mem_rdata (loads only), then move to DONE with err_code=00.
  - Counter reaching TIMEOUT-1 without ack: move to DONE with err_code=10, load_data=0.
  - If ack and timeout occur at the same edge, ack wins.
- DONE: done=1 for exactly one cycle, then IDLE. load_data and err_code hold until the next accepted request.
- Latency: request accepted at edge E0, ack at edge E1 = E0+1 gives done high in cycle E1..E2, and req_ready returns at E2. Minimum throughput is one access per 3 cycles. req_valid while busy is ignored; the requester holds its request.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. For stores: 000 SB, 001 SH, 010 SW. All others are illegal.
- Alignment: halfword accesses require addr[0]=0; word accesses require addr[1:0]=00.
- mem_addr = {(addr-DMEM_BASE)[31:2], 2'b00}, with 32-bit wrap-around and no range check.
- Stores:
  - SB: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{store_data[7:0]}}.
  - SH: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{store_data[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = store_data.
  - load_data is unchanged by a store.
- Loads:
  - mem_be = 4'b1111 and mem_we = 0.
  - Shift mem_rdata right by 8*addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes the word through.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN
- Defined: a misaligned request gets err_code=01 and no memory access, with done one cycle after accept.
- Undefined: offending low address bits are cleared (halfword: addr[0]=0; word: addr[1:0]=00) and the access proceeds normally. err_code=01 never occurs.

Test Plan:
- SW: addr=0x10, data=0xDEADBEEF, ack one cycle later -> mem_addr=0x10, be=1111, wdata=0xDEADBEEF, done one cycle after ack, err=00.
- LB: addr=0x13, rdata=0x80FF1234 -> load_data=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x12 -> 0xFFFF80FF.
- SB: addr=0x21, data=0x000000AB -> be=0010, wdata=0xABABABAB. SH addr=0x22, data=0x1234 -> be=1100, wdata=0x12341234.
- No ack with TIMEOUT=16 -> done after 16 ISSUE cycles, err=10, load_data=0. funct3=011 -> err=11, mem_req never asserted.
- LW at addr=0x102 -> with DMEM_MISALIGN_TRAP_EN: err=01, no mem_req. Without it: mem_addr=0x100, normal completion.
- Reset asserted during ISSUE -> mem_req=0 immediately; a later ack is ignored; req_ready=1 and done never pulses.
